mac_seq: RTL

//  Sequential shift-add multiply-accumulate: res = mcand*mplier + addend.

---
 rtl/mac_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/mac_seq.sv
// Sequential shift-add multiply-accumulate: res = mcand * mplier + addend.
// Shares the start/ready/done_tick handshake of the sequential divider, so
// feeding it (quo, dvsr, rmd) rebuilds the dividend for board cross-checks.
// Latency is fixed at W iterations; there is no early exit on zero operands.
module mac_seq #(
  parameter int unsigned W    = 8,
  parameter int unsigned CBIT = 4   // iteration counter width, 2**CBIT must exceed W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  input  logic [W-1:0]   addend,
  output logic           ready,
  output logic           done_tick,
  output logic [2*W-1:0] res
);

  typedef enum logic [1:0] {StIdle, StOp, StDone} state_e;

  state_e           state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   mc_q, mc_d;
  logic [W-1:0]     mp_q, mp_d;
  logic [CBIT-1:0]  n_q, n_d;
  logic [2*W-1:0]   res_q, res_d;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in idle, so it never queues
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StOp;
      StOp:    if (n_q == CBIT'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready     = 1'b0;
    done_tick = 1'b0;
    unique case (state_q)
      StIdle:  ready     = 1'b1;
      StDone:  done_tick = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: load operands on start, shift-add while iterating
  always_comb begin
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    n_d   = n_q;
    res_d = res_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d = {{W{1'b0}}, addend};
          mc_d  = {{W{1'b0}}, mcand};
          mp_d  = mplier;
          n_d   = CBIT'(W);
        end
      end
      StOp: begin
        // Sum cannot exceed 2**(2W) - 2**W, so no carry out is lost
        if (mp_q[0]) acc_d = acc_q + mc_q;
        mc_d = mc_q << 1;
        mp_d = mp_q >> 1;
        n_d  = n_q - CBIT'(1);
        // Capture the final sum on entry to done; res holds it until the next result
        if (n_q == CBIT'(1)) res_d = acc_d;
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      n_q   <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      n_q   <= n_d;
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule
